lsu_mem_master: RTL
===================

// Module: lsu_mem_master
// PURPOSE
// - Load/store initiator for the MEM stage: accepts one RV32I load/store per request and drives the
//   data memory's rd/wr/cs_n/addr/write_data pins, then returns extended load data or an error.
// - Issues only word-aligned memory accesses. Sub-word stores use read-modify-write, because the
//   memory always writes 4 bytes. One request is in flight at a time.
// PARAMETERS
// - ADDR_W     32       address width on both sides
// - MEM_BYTES  2**20    legal byte span; the access is legal only if (addr & ~3) + 3 < MEM_BYTES
// PORTS
// - clk              in   1   rising-edge clock
// - rst              in   1   reset: synchronous, active-high
// - req_valid        in   1   request present
// - req_ready        out  1   1 only in IDLE, and only when rst=0; accept = req_valid & req_ready
// - req_we           in   1   1 = store, 0 = load
// - req_funct3       in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (RV32I encoding)
// - req_addr         in   ADDR_W  byte address
// - req_wdata        in   32  store data; only the low byte/half is used for B/H
// - resp_valid       out  1   one-cycle pulse when the operation completes
// - resp_rdata       out  32  extended load data; 0 for stores and errors
// - resp_err         out  1   qualified by resp_valid: misaligned, out of range, or illegal funct3
// - mem_cs_n         out  1   memory chip select, active-low
// - mem_rd           out  1   memory read enable
// - mem_wr           out  1   memory write enable (memory commits the write at the clk edge)
// - mem_addr         out  ADDR_W  always {addr[ADDR_W-1:2],2'b00}
// - mem_wdata        out  32  full word to write
// - mem_rdata        in   32  memory read data, combinational from mem_addr
// BEHAVIOUR
// - States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP. Request fields are latched on accept.
// - Transitions from IDLE on accept:
//   - error -> RESP
//   - load -> LOAD
//   - SW -> STORE
//   - SB/SH -> RMW_RD
// - Other transitions:
//   - LOAD -> RESP
//   - STORE -> RESP
//   - RMW_RD -> RMW_WR
//   - RMW_WR -> RESP
//   - RESP -> IDLE (always)
// - Error conditions, checked on accept:
//   - H/HU with addr[0]=1
//   - W with addr[1:0]!=0
//   - funct3 is 011, 110 or 111
//   - store with funct3 100 or 101
//   - range check fails
//   On error: no memory strobe at all, resp_err=1, resp_rdata=0.
// - Memory pins per state:
//   - LOAD, RMW_RD: cs_n=0, rd=1, wr=0. mem_rdata is captured at the end of the cycle.
//   - STORE, RMW_WR: cs_n=0, wr=1, rd=0.
//   - All other states: cs_n=1, rd=0, wr=0, addr=0, wdata=0.
//   Memory pins decode from the state register and latched fields only, never from req_* inputs.
// - Latency, with accept in cycle 0:
//   - error: resp_valid in cycle 1
//   - LW/LB/LH/SW: resp_valid in cycle 2
//   - SB/SH: resp_valid in cycle 3
//   - req_ready returns one cycle after resp_valid.
// - Load extraction:
//   - byte lane = addr[1:0], half lane = addr[1]
//   - B/H sign-extend bit 7/15; BU/HU zero-extend
// - Store merge:
//   - RMW_WR writes the captured word with the selected lane replaced by wdata[7:0] or [15:0].
//   - Other bytes are written back unchanged.
// - Reset:
//   - rst=1 forces mem_cs_n=1, mem_rd=0, mem_wr=0 combinationally, so no write lands in a reset cycle.
//   - At the clock edge: state=IDLE, resp_valid=0, resp_err=0, resp_rdata=0.
//   - An operation in flight is abandoned: no resp_valid, and no write if still before RMW_WR/STORE.
// - req_valid outside IDLE is ignored, not queued. resp_rdata holds its value until the next RESP.
// STRUCTURE
// - Package lsu_pkg holds:
//   - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
//   - state encodings
//   - LANE_* widths
// - Sub-module lsu_lane_align (combinational) does the load extraction and store merge. The FSM is top-level.
// TESTING
// - Reset: rst=1 for 2 cycles -> req_ready=0, mem_cs_n=1, resp_valid=0; after release, req_ready=1.
// - SW 0xDEADBEEF @0x100, then LW @0x100 -> mem_wr pulse in cycle 1; resp_rdata=0xDEADBEEF, resp_valid in cycle 2.
// - Word @0x100 = 0x11223344, then SB 0x80 @0x101 -> RMW gives word 0x11228044.
//   Then LB @0x101 -> 0xFFFFFF80, and LBU @0x101 -> 0x00000080.
// - SH 0xBEEF @0x102 -> word 0xBEEF8044. LH @0x102 -> 0xFFFFBEEF; LHU -> 0x0000BEEF.
// - Error cases:
//   - LW @0x102 -> resp_err in cycle 1, no strobes
//   - LW @0x000FFFFC -> OK
//   - LW @0x00100000 -> err
//   - SB with funct3=100 -> err
// - SB @0x101 with rst raised during RMW_RD -> mem_wr never 1, no resp_valid, word stays 0x11223344.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the MEM-stage load/store master.
// Holds funct3 encodings, FSM state codes, lane widths and the request-legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   localparam int LANE_B_W = 8;
   localparam int LANE_H_W = 16;
   localparam int WORD_W   = 32;

   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [WORD_W-1:0] wdata;
   } req_t;

   // Alignment / encoding error for a request; the range check is done separately.
   function automatic logic f3_err(input logic [2:0] f3, input logic we, input logic [1:0] lo);
      logic e;
      case (f3)
         F3_B:    e = 1'b0;
         F3_H:    e = lo[0];
         F3_W:    e = (lo != 2'b00);
         F3_BU:   e = we;
         F3_HU:   e = we | lo[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational byte/half lane handling: load extraction with sign/zero extension
// and read-modify-write merge of a sub-word store into the captured memory word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [1:0]        byte_off,
   input  logic [WORD_W-1:0] load_word,
   input  logic [WORD_W-1:0] merge_word,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] load_data,
   output logic [WORD_W-1:0] merged_word
);

   logic [LANE_B_W-1:0] byte_s;
   logic [LANE_H_W-1:0] half_s;

   // Select the addressed lane and extend it to a full word.
   always_comb begin
      case (byte_off)
         2'b00:   byte_s = load_word[7:0];
         2'b01:   byte_s = load_word[15:8];
         2'b10:   byte_s = load_word[23:16];
         2'b11:   byte_s = load_word[31:24];
         default: byte_s = load_word[7:0];
      endcase
      half_s = byte_off[1] ? load_word[31:16] : load_word[15:0];
      case (funct3)
         F3_B:    load_data = {{(WORD_W-LANE_B_W){byte_s[LANE_B_W-1]}}, byte_s};
         F3_H:    load_data = {{(WORD_W-LANE_H_W){half_s[LANE_H_W-1]}}, half_s};
         F3_W:    load_data = load_word;
         F3_BU:   load_data = {{(WORD_W-LANE_B_W){1'b0}}, byte_s};
         F3_HU:   load_data = {{(WORD_W-LANE_H_W){1'b0}}, half_s};
         default: load_data = {WORD_W{1'b0}};
      endcase
   end

   // Replace only the targeted lane; untouched bytes go back exactly as read.
   always_comb begin
      merged_word = merge_word;
      case (funct3)
         F3_B: begin
            case (byte_off)
               2'b00:   merged_word[7:0]   = wdata[LANE_B_W-1:0];
               2'b01:   merged_word[15:8]  = wdata[LANE_B_W-1:0];
               2'b10:   merged_word[23:16] = wdata[LANE_B_W-1:0];
               2'b11:   merged_word[31:24] = wdata[LANE_B_W-1:0];
               default: merged_word = merge_word;
            endcase
         end
         F3_H: begin
            if (byte_off[1]) begin
               merged_word[31:16] = wdata[LANE_H_W-1:0];
            end else begin
               merged_word[15:0] = wdata[LANE_H_W-1:0];
            end
         end
         default: merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// MEM-stage load/store initiator: one request in flight, word-aligned memory accesses,
// sub-word stores by read-modify-write, registered response.
module lsu_mem_master
   import lsu_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int MEM_BYTES = 2**20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_cs_n,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [2:0]        state_r;
   logic [2:0]        next_state_s;
   req_t              req_r;
   logic [ADDR_W-1:0] addr_r;
   logic [31:0]       word_r;
   logic              accept_s;
   logic              err_s;
   logic [ADDR_W:0]   last_byte_s;
   logic              range_ok_s;
   logic [31:0]       load_data_s;
   logic [31:0]       merged_word_s;
   logic              mem_cs_n_s;
   logic              mem_rd_s;
   logic              mem_wr_s;

   assign req_ready = (state_r == ST_IDLE) & ~rst;
   assign accept_s  = req_valid & req_ready;

   // One extra bit so an access near the top of the address space cannot wrap into range.
   assign last_byte_s = {1'b0, req_addr[ADDR_W-1:2], 2'b00} + (ADDR_W+1)'(3);
   assign range_ok_s  = last_byte_s < (ADDR_W+1)'(MEM_BYTES);
   assign err_s       = f3_err(req_funct3, req_we, req_addr[1:0]) | ~range_ok_s;

   lsu_lane_align u_lane_align (
      .funct3      (req_r.funct3),
      .byte_off    (addr_r[1:0]),
      .load_word   (mem_rdata),
      .merge_word  (word_r),
      .wdata       (req_r.wdata),
      .load_data   (load_data_s),
      .merged_word (merged_word_s)
   );

   // Next-state decode.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (!accept_s) begin
               next_state_s = ST_IDLE;
            end else if (err_s) begin
               next_state_s = ST_RESP;
            end else if (!req_we) begin
               next_state_s = ST_LOAD;
            end else if (req_funct3 == F3_W) begin
               next_state_s = ST_STORE;
            end else begin
               next_state_s = ST_RMW_RD;
            end
         end
         ST_LOAD:   next_state_s = ST_RESP;
         ST_STORE:  next_state_s = ST_RESP;
         ST_RMW_RD: next_state_s = ST_RMW_WR;
         ST_RMW_WR: next_state_s = ST_RESP;
         ST_RESP:   next_state_s = ST_IDLE;
         default:   next_state_s = ST_IDLE;
      endcase
   end

   // State, latched request and registered response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         req_r      <= '0;
         addr_r     <= '0;
         word_r     <= 32'h0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
      end else begin
         state_r    <= next_state_s;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  req_r.we     <= req_we;
                  req_r.funct3 <= req_funct3;
                  req_r.wdata  <= req_wdata;
                  addr_r       <= req_addr;
                  if (err_s) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'h0;
                  end
               end
            end
            ST_LOAD: begin
               resp_valid <= 1'b1;
               resp_rdata <= load_data_s;
            end
            ST_STORE, ST_RMW_WR: begin
               resp_valid <= 1'b1;
               resp_rdata <= 32'h0;
            end
            ST_RMW_RD: word_r <= mem_rdata;
            default: ;
         endcase
      end
   end

   // Memory pin decode from the state register and latched fields only.
   always_comb begin
      mem_cs_n_s = 1'b1;
      mem_rd_s   = 1'b0;
      mem_wr_s   = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 32'h0;
      case (state_r)
         ST_LOAD, ST_RMW_RD: begin
            mem_cs_n_s = 1'b0;
            mem_rd_s   = 1'b1;
            mem_addr   = {addr_r[ADDR_W-1:2], 2'b00};
         end
         ST_STORE: begin
            mem_cs_n_s = 1'b0;
            mem_wr_s   = 1'b1;
            mem_addr   = {addr_r[ADDR_W-1:2], 2'b00};
            mem_wdata  = req_r.wdata;
         end
         ST_RMW_WR: begin
            mem_cs_n_s = 1'b0;
            mem_wr_s   = 1'b1;
            mem_addr   = {addr_r[ADDR_W-1:2], 2'b00};
            mem_wdata  = merged_word_s;
         end
         default: ;
      endcase
   end

   // Reset gates the strobes immediately so no write can land in a reset cycle.
   assign mem_cs_n = mem_cs_n_s | rst;
   assign mem_rd   = mem_rd_s & ~rst;
   assign mem_wr   = mem_wr_s & ~rst;

endmodule
